// File: rtl/ext_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : ext_pipe_unit
// Purpose  : Registered immediate extender for the ID stage. Each accepted
//            immediate is extended at push time according to its mode and
//            is then held in a 2-entry in-order buffer. The buffer absorbs
//            EX-stage stalls and can be emptied by a synchronous flush.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   reset      in   asynchronous active-low reset
//   flush      in   synchronous kill of all buffered entries
//   in_valid   in   input entry present
//   in_ready   out  buffer can accept an entry this cycle
//   in_imm     in   raw immediate [IN_W]
//   in_mode    in   00 zero, 01 sign, 10 high, 11 branch offset
//   in_tag     in   side-band tag [TAG_W], passed through unchanged
//   out_valid  out  head entry valid
//   out_ready  in   consumer accepts the head entry this cycle
//   out_data   out  extended value of the head entry [OUT_W]
//   out_mode   out  mode of the head entry
//   out_tag    out  tag of the head entry
//   stat_sign_neg out [16] (only with EXT_PIPE_STATS_EN) saturating count
//              of sign/branch-mode pushes whose immediate MSB is set
// Optional build macro: EXT_PIPE_STATS_EN
// ============================================================================
module ext_pipe_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [TAG_W-1:0] out_tag
`ifdef EXT_PIPE_STATS_EN
  ,
  output logic [15:0]      stat_sign_neg
`endif
);

  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_SIGN   = 2'b01;
  localparam logic [1:0] MODE_HIGH   = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  // Buffer storage and bookkeeping. count in {0,1,2} doubles as the
  // EMPTY/ONE/FULL state; the pointers are single bits that wrap 1 -> 0.
  logic [OUT_W-1:0] data_mem [2];
  logic [1:0]       mode_mem [2];
  logic [TAG_W-1:0] tag_mem  [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic             push;
  logic             pop;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_value;

  // in_ready depends only on registered count, flush and reset so that no
  // combinational path exists from out_ready back to in_ready.
  assign in_ready  = reset && (count != 2'd2) && !flush;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = data_mem[rd_ptr];
  assign out_mode  = mode_mem[rd_ptr];
  assign out_tag   = tag_mem[rd_ptr];

  // Size casts handle IN_W == OUT_W cleanly: the extension collapses to a
  // pass-through and the high-mode shift amount becomes zero.
  assign zext = OUT_W'(in_imm);
  assign sext = OUT_W'($signed(in_imm));

  always_comb begin
    ext_value = zext;
    case (in_mode)
      MODE_ZERO:   ext_value = zext;
      MODE_SIGN:   ext_value = sext;
      MODE_HIGH:   ext_value = zext << (OUT_W - IN_W);
      MODE_BRANCH: ext_value = sext << 2;
      default:     ext_value = zext;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        mode_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
    end else if (flush) begin
      // Storage contents are left as-is; out_valid=0 hides them.
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= ext_value;
        mode_mem[wr_ptr] <= in_mode;
        tag_mem[wr_ptr]  <= in_tag;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef EXT_PIPE_STATS_EN
  // push already excludes flushed cycles because in_ready is low then.
  // The counter survives flush and only clears on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_sign_neg <= 16'd0;
    end else if (push && in_mode[0] && in_imm[IN_W-1] &&
                 (stat_sign_neg != 16'hFFFF)) begin
      stat_sign_neg <= stat_sign_neg + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ext_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_pipe_unit
// Purpose  : Self-checking bench for ext_pipe_unit with a queue-based
//            reference model of the extender and its 2-entry buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_pipe_unit;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  mode;
    logic [4:0]  tag;
  } entry_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;
  logic [TAG_W-1:0] out_tag;
`ifdef EXT_PIPE_STATS_EN
  logic [15:0]      stat_sign_neg;
`endif

  int     vectors    = 0;
  int     miscompares = 0;
  entry_t exp_q[$];
  int     exp_stat   = 0;

  ext_pipe_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_tag   (out_tag)
`ifdef EXT_PIPE_STATS_EN
    ,
    .stat_sign_neg (stat_sign_neg)
`endif
  );

  always #5 clk = ~clk;

  // Reference extension from the mode definitions using plain arithmetic.
  function automatic logic [31:0] ref_ext(logic [15:0] imm, logic [1:0] mode);
    int s;
    s = $signed(imm);
    case (mode)
      2'b00:   return {16'h0000, imm};
      2'b01:   return s;
      2'b10:   return imm * 32'h0001_0000;
      default: return s * 4;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [4:0] tag, input logic ordy, input logic fl);
    in_valid  = v;
    in_imm    = imm;
    in_mode   = mode;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  // Advance one clock: decide handshakes from the model, update it at the
  // edge, and return at the following falling edge.
  task automatic tick();
    logic   push, pop;
    entry_t e;
    push = in_valid && (exp_q.size() < 2) && !flush;
    pop  = (exp_q.size() != 0) && out_ready;
    e.data = ref_ext(in_imm, in_mode);
    e.mode = in_mode;
    e.tag  = in_tag;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(e);
    end
    if (push && in_mode[0] && in_imm[15] && exp_stat != 16'hFFFF) exp_stat++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    exp_q.delete();
    exp_stat = 0;
    drive(1'b0, 16'h0, 2'b00, 5'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 16'h0, 2'b00, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_mode !== 2'b00 ||
        out_tag !== 5'd0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b data=%h mode=%b tag=%h in_ready=%b, required 0/0/0/0/0",
               out_valid, out_data, out_mode, out_tag, in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    exp_stat = 0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_zero_ext();
    drive(1'b1, 16'h000A, 2'b00, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0, 2'b00, 5'd0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_000A || out_tag !== 5'd3) begin
      miscompares++;
      $display("FAIL zero_ext: valid=%b data=%h tag=%0d, required 1 0000000a 3",
               out_valid, out_data, out_tag);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_ext_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] imms [3];
    logic [1:0]  modes[3];
    logic [31:0] want [3];
    imms  = '{16'hF001, 16'hF001, 16'hFFFF};
    modes = '{2'b01, 2'b10, 2'b11};
    want  = '{32'hFFFF_F001, 32'hF001_0000, 32'hFFFF_FFFC};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, imms[i], modes[i], 5'(i + 7), 1'b1, 1'b0);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== want[i] || out_mode !== modes[i]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: valid=%b data=%h mode=%b, required 1 %h %b",
                 i, out_valid, out_data, out_mode, want[i], modes[i]);
      end
    end
    drive(1'b0, 16'h0, 2'b00, 5'd0, 1'b1, 1'b0);
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 16'h0001, 2'b00, 5'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0002, 2'b00, 5'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 2'b00, 5'd0, 1'b0, 1'b0);
    vectors++;
    if (in_ready !== 1'b0 || out_data !== 32'h1) begin
      miscompares++;
      $display("FAIL backpressure_full: in_ready=%b data=%h, required 0 00000001", in_ready, out_data);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h1) begin
      miscompares++;
      $display("FAIL backpressure_hold: valid=%b data=%h, required 1 00000001", out_valid, out_data);
    end
    drive(1'b0, 16'h0, 2'b00, 5'd0, 1'b1, 1'b0);
    tick();
    vectors++;
    if (out_data !== 32'h2 || in_ready !== 1'b1 || out_tag !== 5'd2) begin
      miscompares++;
      $display("FAIL backpressure_release: data=%h in_ready=%b tag=%0d, required 00000002 1 2",
               out_data, in_ready, out_tag);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 16'h0011, 2'b00, 5'd4, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0022, 2'b00, 5'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0003, 2'b00, 5'd6, 1'b0, 1'b1);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_in_ready: in_ready=%b, required 0", in_ready);
    end
    tick();
    drive(1'b0, 16'h0, 2'b00, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_empty[%0d]: out_valid=%b data=%h, required 0", i, out_valid, out_data);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'h1234, 2'b00, 5'd9, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 2'b00, 5'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b data=%h in_ready=%b, required 0 00000000 0",
               out_valid, out_data, in_ready);
    end
    exp_q.delete();
    exp_stat = 0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_hold: in_ready=%b, required 0", in_ready);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_release: in_ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    entry_t h;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom), 5'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      vectors++;
      if (in_ready !== ((exp_q.size() < 2) && !flush) ||
          out_valid !== (exp_q.size() != 0)) begin
        miscompares++;
        $display("FAIL random_hs[%0d]: in_ready=%b valid=%b, required %b %b", i, in_ready,
                 out_valid, (exp_q.size() < 2) && !flush, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        vectors++;
        if (out_data !== h.data || out_mode !== h.mode || out_tag !== h.tag) begin
          miscompares++;
          $display("FAIL random_head[%0d]: data=%h mode=%b tag=%h, required %h %b %h",
                   i, out_data, out_mode, out_tag, h.data, h.mode, h.tag);
        end
      end
      tick();
    end
`ifdef EXT_PIPE_STATS_EN
    vectors++;
    if (stat_sign_neg !== 16'(exp_stat)) begin
      miscompares++;
      $display("FAIL random_stat: stat=%0d, required %0d", stat_sign_neg, exp_stat);
    end
`endif
    drive(1'b0, 16'h0, 2'b00, 5'd0, 1'b1, 1'b0);
    repeat (2) tick();
  endtask

`ifdef EXT_PIPE_STATS_EN
  task automatic test_stats();
    apply_reset();
    drive(1'b1, 16'h8000, 2'b01, 5'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h8000, 2'b00, 5'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'hFFFF, 2'b11, 5'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'hFFFF, 2'b01, 5'd0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0, 2'b00, 5'd0, 1'b1, 1'b0);
    tick();
    vectors++;
    if (stat_sign_neg !== 16'd2) begin
      miscompares++;
      $display("FAIL stat_sign_neg: stat=%0d, required 2", stat_sign_neg);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_ext();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
`ifdef EXT_PIPE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
